opc_byte_serializer: RTL

//   Transmit side of the 8-bit opcode/address byte bus.
//   - Accepts 16-bit instruction words {opcode, ir_addr} over a valid/ready handshake.
//   - Emits each word as two bytes on consecutive clk1 cycles, high byte first,

---
 rtl/risc_bus_pkg.sv | 16 +
 rtl/opc_ser_pend_buf.sv | 31 +++
 rtl/opc_byte_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/risc_bus_pkg.sv
// Shared widths and serializer state encodings for the opcode/address byte bus.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package risc_bus_pkg;

    localparam int BYTE_W = 8;
    localparam int OPC_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2,
        S_GAP  = 2'd3
    } ser_state_t;

endpackage

// File: rtl/opc_ser_pend_buf.sv
// One-entry holding register for an instruction word waiting on the serializer.
// Latency: stored word visible on pend_word the cycle after the write.
// Backpressure: wr_ready low while full; rd_pop frees the slot on that edge.
module opc_ser_pend_buf
    import risc_bus_pkg::*;
(
    input  logic             clk1,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [OPC_W-1:0] wr_word,
    input  logic             rd_pop,
    output logic             pend_vld,
    output logic [OPC_W-1:0] pend_word
);

    assign wr_ready = !pend_vld;

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            pend_vld  <= 1'b0;
            pend_word <= '0;
        end else if (rd_pop) begin
            pend_vld <= 1'b0;
        end else if (wr_valid && wr_ready) begin
            pend_vld  <= 1'b1;
            pend_word <= wr_word;
        end
    end

endmodule

// File: rtl/opc_byte_serializer.sv
// Splits 16-bit {opcode, ir_addr} words into two bytes, high first, ena held across both.
// Latency: accept at edge N -> high byte in cycle N+1, low byte in N+2. Optional par via OPC_SER_PARITY_EN.
// Backpressure: wr_ready = !pend_vld; the byte side never stalls.
module opc_byte_serializer
    import risc_bus_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [OPC_W-1:0]  wr_word,
    output logic              ena,
    output logic [BYTE_W-1:0] data,
    output logic              word_done,
    output logic              busy
`ifdef OPC_SER_PARITY_EN
    ,
    output logic              par
`endif
);

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    ser_state_t        state;
    logic [3:0]        gap_cnt;
    logic [BYTE_W-1:0] cur_lo;

    logic              pend_vld;
    logic [OPC_W-1:0]  pend_word;
    logic              accept;
    logic              word_avail;
    logic              take;
    logic              load;
    logic [OPC_W-1:0]  next_word;

    assign accept     = wr_valid && wr_ready;
    assign word_avail = pend_vld || accept;
    // Pending word always goes first so ordering is preserved.
    assign next_word  = pend_vld ? pend_word : wr_word;
    assign load       = take && word_avail;
    assign busy       = (state != S_IDLE) || pend_vld;

    always_comb begin
        take = 1'b0;
        case (state)
            S_IDLE:  take = 1'b1;
            S_LO:    take = (GAP_CYCLES == 0);
            S_GAP:   take = (gap_cnt == 4'd0);
            default: take = 1'b0;
        endcase
    end

    // A word arriving exactly when the FSM takes one bypasses the holding register.
    opc_ser_pend_buf u_pend (
        .clk1      (clk1),
        .rst       (rst),
        .wr_valid  (wr_valid && !take),
        .wr_ready  (wr_ready),
        .wr_word   (wr_word),
        .rd_pop    (take && pend_vld),
        .pend_vld  (pend_vld),
        .pend_word (pend_word)
    );

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            gap_cnt   <= 4'd0;
            cur_lo    <= '0;
            ena       <= 1'b0;
            data      <= '0;
            word_done <= 1'b0;
`ifdef OPC_SER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            if (load) begin
                state  <= S_HI;
                ena    <= 1'b1;
                data   <= next_word[OPC_W-1:BYTE_W];
                cur_lo <= next_word[BYTE_W-1:0];
`ifdef OPC_SER_PARITY_EN
                par    <= ^next_word[OPC_W-1:BYTE_W];
`endif
            end else begin
                case (state)
                    S_HI: begin
                        state     <= S_LO;
                        data      <= cur_lo;
                        word_done <= 1'b1;
`ifdef OPC_SER_PARITY_EN
                        par       <= ^cur_lo;
`endif
                    end
                    S_LO: begin
                        ena <= 1'b0;
`ifdef OPC_SER_PARITY_EN
                        par <= 1'b0;
`endif
                        if (GAP_CYCLES == 0) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == 4'd0) state <= S_IDLE;
                        else                 gap_cnt <= gap_cnt - 4'd1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
